// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-stream loader port of the instruction ROM.
// master: core/loader side, slave: the ROM responder.
interface inst_rom_loader_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  rom_ce_i;
    logic [31:0]           rom_addr_i;
    logic [31:0]           rom_data_o;
    logic                  ld_start;
    logic                  ld_valid;
    logic [7:0]            ld_data;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  rom_done;
    logic                  ld_ovf;
    logic [DEPTH_LOG2:0]   word_cnt;

    modport master (
        output rom_ce_i, rom_addr_i, ld_start, ld_valid, ld_data, ld_last,
        input  rom_data_o, ld_ready, rom_done, ld_ovf, word_cnt
    );

    modport slave (
        input  rom_ce_i, rom_addr_i, ld_start, ld_valid, ld_data, ld_last,
        output rom_data_o, ld_ready, rom_done, ld_ovf, word_cnt
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction memory for the fetch port, filled at run time from a
// big-endian byte stream. Fetches read as NOP until a load completes.
//
// state | meaning
// IDLE  | after reset, waiting for ld_start, loader bytes ignored
// LOAD  | accepting bytes, assembling words MSB first
// DONE  | program loaded, fetches served, loader bytes ignored
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input logic              clk,
    input logic              rst,
    inst_rom_loader_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DEPTH_LOG2:0] DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  ld_ready;
    logic                  rom_done;
    logic                  ld_ovf;
    logic [DEPTH_LOG2:0]   word_cnt;
    logic [1:0]            lane;
    logic [23:0]           byte_buf;
    logic [31:0]           wdata;
    logic                  accept;
    logic                  full;
    logic                  write_en;
    logic [31:0]           rom_data;
    logic                  addr_unused;

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // ld_start takes priority, so a byte presented with it is not accepted
    assign accept   = ld_ready && bus.ld_valid && !bus.ld_start;
    assign full     = (word_cnt == DEPTH_WORDS);
    assign write_en = accept && !full && ((lane == 2'd3) || bus.ld_last);

    // Word as it would be written with the current byte; lanes not yet
    // filled come out as zero, so stale buffer bytes never leak into a
    // partial final word.
    always_comb begin
        wdata = 32'h0;
        case (lane)
            2'd0:    wdata = {bus.ld_data, 24'h0};
            2'd1:    wdata = {byte_buf[23:16], bus.ld_data, 16'h0};
            2'd2:    wdata = {byte_buf[23:8], bus.ld_data, 8'h0};
            default: wdata = {byte_buf, bus.ld_data};
        endcase
    end

    // Next state: start/restart from anywhere, last accepted byte ends load
    always_comb begin
        state_nxt = state;
        if (bus.ld_start) begin
            state_nxt = ST_LOAD;
        end else if (accept && bus.ld_last) begin
            state_nxt = ST_DONE;
        end
    end

    // Control state, counters and byte assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ld_ready <= 1'b0;
            rom_done <= 1'b0;
            ld_ovf   <= 1'b0;
            word_cnt <= '0;
            lane     <= 2'd0;
            byte_buf <= 24'h0;
        end else begin
            state    <= state_nxt;
            ld_ready <= (state_nxt == ST_LOAD);
            rom_done <= (state_nxt == ST_DONE);
            if (bus.ld_start) begin
                word_cnt <= '0;
                lane     <= 2'd0;
                ld_ovf   <= 1'b0;
            end else if (accept) begin
                if (full) begin
                    ld_ovf <= 1'b1;
                end else if ((lane == 2'd3) || bus.ld_last) begin
                    word_cnt <= word_cnt + (DEPTH_LOG2 + 1)'(1);
                    lane     <= 2'd0;
                end else begin
                    lane <= lane + 2'd1;
                    case (lane)
                        2'd0:    byte_buf[23:16] <= bus.ld_data;
                        2'd1:    byte_buf[15:8]  <= bus.ld_data;
                        default: byte_buf[7:0]   <= bus.ld_data;
                    endcase
                end
            end
        end
    end

    // Memory array is deliberately not reset
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[word_cnt[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

    // Zero-latency fetch, masked to NOP until loaded or when out of range
    always_comb begin
        rom_data = 32'h0;
        if (bus.rom_ce_i && rom_done && (bus.rom_addr_i[31:DEPTH_LOG2+2] == '0)) begin
            rom_data = mem[bus.rom_addr_i[DEPTH_LOG2+1:2]];
        end
    end

    // Byte offset within the word has no meaning for word fetches
    assign addr_unused = ^bus.rom_addr_i[1:0];

    assign bus.rom_data_o = rom_data;
    assign bus.ld_ready   = ld_ready;
    assign bus.rom_done   = rom_done;
    assign bus.ld_ovf     = ld_ovf;
    assign bus.word_cnt   = word_cnt;
endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a 1024-word instance for the main
// load/fetch/abort cases and a 4-word instance for overflow and reset.
module tb_inst_rom_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        start_big;
    logic        start_small;

    int checks = 0;
    int errors = 0;

    inst_rom_loader_if #(.DEPTH_LOG2(10)) u ();
    inst_rom_loader_if #(.DEPTH_LOG2(2))  s ();

    assign u.rom_ce_i   = rom_ce;
    assign u.rom_addr_i = rom_addr;
    assign u.ld_start   = start_big;
    assign u.ld_valid   = ld_valid;
    assign u.ld_data    = ld_data;
    assign u.ld_last    = ld_last;
    assign s.rom_ce_i   = rom_ce;
    assign s.rom_addr_i = rom_addr;
    assign s.ld_start   = start_small;
    assign s.ld_valid   = ld_valid;
    assign s.ld_data    = ld_data;
    assign s.ld_last    = ld_last;

    inst_rom_loader #(.DEPTH_LOG2(10)) dut_big   (.clk(clk), .rst(rst), .bus(u));
    inst_rom_loader #(.DEPTH_LOG2(2))  dut_small (.clk(clk), .rst(rst), .bus(s));

    always #5 clk = ~clk;

    typedef struct {
        bit          big;
        int          phase;
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } fvec_t;

    fvec_t vecs[$];

    function automatic fvec_t mk(input bit big, input int phase, input logic ce,
                                 input logic [31:0] addr, input logic [31:0] exp);
        fvec_t v;
        v.big = big; v.phase = phase; v.ce = ce; v.addr = addr; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit big);
        if (big) start_big = 1'b1;
        else     start_small = 1'b1;
        tick();
        start_big   = 1'b0;
        start_small = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input int gap);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic run_fetch(input int phase);
        logic [31:0] act;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == phase) begin
                rom_ce   = vecs[i].ce;
                rom_addr = vecs[i].addr;
                #1;
                act = vecs[i].big ? u.rom_data_o : s.rom_data_o;
                check($sformatf("fetch p%0d addr 0x%0h ce %0d", phase, vecs[i].addr, vecs[i].ce),
                      act, vecs[i].exp);
            end
        end
        rom_ce   = 1'b0;
        rom_addr = 32'h0;
    endtask

    initial begin
        logic [7:0] prog1 [8];
        prog1 = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};

        rom_ce = 1'b0; rom_addr = 32'h0;
        ld_valid = 1'b0; ld_data = 8'h0; ld_last = 1'b0;
        start_big = 1'b0; start_small = 1'b0;

        vecs.push_back(mk(1, 0, 1, 32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h0,    32'h0));
        vecs.push_back(mk(1, 1, 1, 32'h0,    32'h34011100));
        vecs.push_back(mk(1, 1, 1, 32'h4,    32'h34020020));
        vecs.push_back(mk(1, 1, 1, 32'h6,    32'h34020020));
        vecs.push_back(mk(1, 1, 0, 32'h0,    32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h4,    32'h0));
        vecs.push_back(mk(1, 2, 1, 32'h0,    32'hAABBCCDD));
        vecs.push_back(mk(1, 2, 1, 32'h3,    32'hAABBCCDD));
        vecs.push_back(mk(1, 2, 1, 32'h4,    32'hEE000000));
        vecs.push_back(mk(1, 2, 1, 32'h1000, 32'h0));
        vecs.push_back(mk(1, 3, 1, 32'h0,    32'h55667788));
        vecs.push_back(mk(1, 3, 1, 32'h4,    32'hEE000000));
        vecs.push_back(mk(0, 4, 1, 32'h0,    32'h10111213));
        vecs.push_back(mk(0, 4, 1, 32'h4,    32'h14151617));
        vecs.push_back(mk(0, 4, 1, 32'h8,    32'h18191A1B));
        vecs.push_back(mk(0, 4, 1, 32'hC,    32'h1C1D1E1F));
        vecs.push_back(mk(0, 4, 1, 32'h10,   32'h0));
        vecs.push_back(mk(0, 5, 1, 32'h0,    32'h0));

        // reset state
        #2 rst = 1'b0;
        #1;
        check("rst ld_ready", 32'(u.ld_ready), 32'd0);
        check("rst rom_done", 32'(u.rom_done), 32'd0);
        check("rst ld_ovf",   32'(u.ld_ovf),   32'd0);
        check("rst word_cnt", 32'(u.word_cnt), 32'd0);
        run_fetch(0);
        tick();
        rst = 1'b1;
        tick();

        // bytes before any start are ignored
        send(8'hFF, 1'b1, 0);
        check("idle ignores bytes", 32'(u.rom_done), 32'd0);

        // load 1: 8 bytes back to back, last completes a word
        start(1'b1);
        check("start ld_ready", 32'(u.ld_ready), 32'd1);
        check("start word_cnt", 32'(u.word_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog1[i];
            ld_last  = (i == 7);
            tick();
            if (i == 3) check("load1 word_cnt mid", 32'(u.word_cnt), 32'd1);
            if (i == 6) check("load1 done before last", 32'(u.rom_done), 32'd0);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("load1 word_cnt", 32'(u.word_cnt), 32'd2);
        check("load1 rom_done", 32'(u.rom_done), 32'd1);
        check("load1 ld_ready", 32'(u.ld_ready), 32'd0);
        run_fetch(1);

        // load 2: gapped stream, partial final word
        start(1'b1);
        check("reload rom_done", 32'(u.rom_done), 32'd0);
        send(8'hAA, 1'b0, 1);
        check("gap ld_ready", 32'(u.ld_ready), 32'd1);
        send(8'hBB, 1'b0, 2);
        send(8'hCC, 1'b0, 1);
        send(8'hDD, 1'b0, 1);
        send(8'hEE, 1'b1, 0);
        check("load2 word_cnt", 32'(u.word_cnt), 32'd2);
        check("load2 rom_done", 32'(u.rom_done), 32'd1);
        run_fetch(2);

        // abort after 3 bytes; restart coincides with a valid byte
        start(1'b1);
        send(8'h11, 1'b0, 0);
        send(8'h22, 1'b0, 0);
        send(8'h33, 1'b0, 0);
        start_big = 1'b1; ld_valid = 1'b1; ld_data = 8'h99;
        tick();
        start_big = 1'b0; ld_valid = 1'b0;
        check("abort word_cnt", 32'(u.word_cnt), 32'd0);
        send(8'h55, 1'b0, 0);
        send(8'h66, 1'b0, 0);
        send(8'h77, 1'b0, 0);
        send(8'h88, 1'b1, 0);
        check("abort reload word_cnt", 32'(u.word_cnt), 32'd1);
        run_fetch(3);

        // small instance: overflow past 4 words
        start(1'b0);
        for (int i = 0; i < 20; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(8'h10 + i);
            ld_last  = (i == 19);
            tick();
            if (i == 15) check("ovf clear at full", 32'(s.ld_ovf), 32'd0);
            if (i == 16) begin
                check("ovf set", 32'(s.ld_ovf), 32'd1);
                check("ovf saturate", 32'(s.word_cnt), 32'd4);
                check("ovf not done", 32'(s.rom_done), 32'd0);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("small ld_ovf", 32'(s.ld_ovf), 32'd1);
        check("small word_cnt", 32'(s.word_cnt), 32'd4);
        check("small rom_done", 32'(s.rom_done), 32'd1);
        run_fetch(4);

        // restart clears overflow, then reset mid-load
        start(1'b0);
        check("restart ovf clear", 32'(s.ld_ovf), 32'd0);
        check("restart word_cnt", 32'(s.word_cnt), 32'd0);
        send(8'hA1, 1'b0, 0);
        send(8'hA2, 1'b0, 0);
        rst = 1'b0;
        #1;
        check("async rst ld_ready", 32'(s.ld_ready), 32'd0);
        check("async rst rom_done", 32'(s.rom_done), 32'd0);
        check("async rst big done", 32'(u.rom_done), 32'd0);
        check("async rst word_cnt", 32'(s.word_cnt), 32'd0);
        run_fetch(5);
        #1 rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for the core's fetch port: answers `rom_ce`/`rom_addr` from the pipeline with 32-bit instruction words on `rom_data`, in the same cycle. Its contents are filled at run time by a byte-stream program loader, which assembles big-endian bytes into words. Fetches return NOP (0x00000000) until a load has completed. It sits beside `pc_reg`/`if_id` at the top level, on the far side of the instruction-fetch interface.

## Interface
- `DEPTH_LOG2`, 10, log2 of memory depth in 32-bit words (1024 words default)
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `rom_ce_i`  in  1  fetch enable from the core
- `rom_addr_i`  in  32  fetch byte address from the core
- `rom_data_o`  out  32  instruction word returned to the core, combinational
- `ld_start`  in  1  one-cycle pulse; begin (or restart) a program load
- `ld_valid`  in  1  loader byte valid
- `ld_data`  in  8  loader byte
- `ld_last`  in  1  marks final byte of the program; qualified by `ld_valid`
- `ld_ready`  out  1  block accepts a loader byte this cycle
- `rom_done`  out  1  program loaded; fetches are served
- `ld_ovf`  out  1  sticky; program exceeded memory depth
- `word_cnt`  out  DEPTH_LOG2+1  number of words written by the current/last load

## Operation
- States: IDLE (after reset), LOAD, DONE.
- IDLE: `ld_start` -> LOAD. Loader bytes are ignored.
- Entering LOAD (from any state): clear `word_cnt`, byte lane counter, and `ld_ovf`. Drop `rom_done`.
- LOAD: `ld_ready`=1. A byte is accepted when `ld_valid && ld_ready`.
  - Bytes fill the word MSB first: lane 0 -> [31:24], lane 3 -> [7:0].
  - 4th byte accepted: the assembled word is written to `mem[word_cnt]`, `word_cnt`++, lane counter -> 0.
  - Byte with `ld_last`: the word is written even if partial; unfilled lanes are zero. `word_cnt`++, and the state goes to DONE.
  - `ld_last` on a byte that completes a word: one write only, `word_cnt`++ once.
- Overflow: a byte accepted while `word_cnt == 2**DEPTH_LOG2` sets `ld_ovf`.
  - The byte is dropped: no write, `word_cnt` saturates.
  - `ld_last` still ends the load -> DONE.
- DONE: `rom_done`=1, `ld_ready`=0. `ld_start` -> LOAD, which reloads and overwrites memory.
- `ld_start` during LOAD aborts the load. Counters restart and partially assembled bytes are discarded. Memory is not cleared.
- `ld_start` in the same cycle as an accepted byte: `ld_start` wins and the byte is not accepted.
- Fetch: `rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]]` only when `rom_ce_i` && `rom_done` && `rom_addr_i[31:DEPTH_LOG2+2]==0`. Otherwise `rom_data_o` is 0x00000000.
- `rom_addr_i[1:0]` is ignored.
- Memory array is not reset. Its contents are unspecified until written and are never visible before `rom_done`.

## Timing
- Reset values: state IDLE, `ld_ready`=0, `rom_done`=0, `ld_ovf`=0, `word_cnt`=0, `rom_data_o`=0.
- Reset mid-load: immediate return to IDLE with the values above. Memory contents are retained but invisible.
- Fetch latency is 0 cycles (combinational read), because `if_id` samples the word on the same edge that advances `pc`.
- A memory write at edge N is visible on `rom_data_o` after edge N. Fetches are not possible before DONE anyway.
- `ld_ready` is a registered function of state only. It rises the cycle after `ld_start` and falls the cycle after the `ld_last` byte is accepted.
- `rom_done` rises at the edge that accepts the `ld_last` byte.
- Throughput: 1 byte/cycle sustained; back-to-back `ld_valid` with no bubbles is legal.

## Test plan
- Reset, then fetch addr 0x0 with `rom_ce_i`=1 -> `rom_data_o`=0x00000000, `ld_ready`=0, `rom_done`=0.
- `ld_start`, stream 8 bytes 0x34,0x01,0x11,0x00,0x34,0x02,0x00,0x20 (`ld_last` on the 8th) with no bubbles.
  - `word_cnt`=2, `rom_done`=1.
  - Fetch 0x0 -> 0x34011100; fetch 0x4 -> 0x34020020; fetch 0x6 -> 0x34020020.
  - `rom_ce_i`=0 -> 0.
- Load 5 bytes 0xAA,0xBB,0xCC,0xDD,0xEE (last on 0xEE), with `ld_valid` gaps between bytes.
  - `word_cnt`=2.
  - Fetch 0x4 -> 0xEE000000.
  - Fetch 0x8 -> undefined memory is masked? No: in range, so only a prior-known value is allowed. The bench checks only addresses 0x0 and 0x4.
  - Fetch 0x1000 (out of range for DEPTH_LOG2=10) -> 0.
- With DEPTH_LOG2=2, stream 20 bytes with `ld_last` on the 20th.
  - `ld_ovf`=1, `word_cnt`=4, `rom_done`=1.
  - Words 0-3 hold bytes 0-15.
- Abort and reset cases:
  - `ld_start` after 3 bytes of a load, then a new 4-byte load -> word 0 is the new word, `word_cnt`=1.
  - `rst` asserted mid-load -> `ld_ready`=0 and `rom_done`=0 immediately, without waiting for a clock edge.
